multicycle_control: RTL and testbench

- Sequencing FSM for the rv32i multicycle core.
- Steps each instruction through fetch, decode, execute, memory and writeback using the decoder's control outputs.
- Arbitrates the single shared memory port between instruction fetch and load/store.
- Generates the gated register-file, instruction-register and PC write strobes; the decoder is purely combinational and this block provides all timing.

---
 rtl/multicycle_control.sv | 118 +++++++++++
 tb/tb_multicycle_control.sv | 126 ++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: rv32i multicycle sequencing FSM with shared memory port arbitration.
// Optional memory-wait watchdog enabled by defining MULTICYCLE_TIMEOUT_EN.
module multicycle_control #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
  input  logic            halt_req,
  input  logic            jump,
  input  logic            branch,
  input  logic            branch_if_zero,
  input  logic            zero,
  input  logic [1:0]      rd_select,
  input  logic            rf_write_en,
  input  logic            mem_write_en,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_addr_src,
  output logic            ir_write,
  output logic            mdr_write,
  output logic            rf_write,
  output logic            pc_write,
  output logic            pc_src,
  output logic            busy,
  output logic            fault,
  output logic [XLEN-1:0] instret
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, FAULT} state_t;
  state_t state_q, state_d;
  logic take_q, take_d, take, eoi;
  logic [XLEN-1:0] instret_q, instret_d;
`ifdef MULTICYCLE_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WW-1:0] wait_q, wait_d;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) wait_q <= '0;
    else          wait_q <= wait_d;
  assign fault = (state_q == FAULT);
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
  assign fault = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      take_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      take_q    <= take_d;
      instret_q <= instret_d;
    end
  always_comb begin
    take         = jump | (branch & (branch_if_zero ~^ zero));
    state_d      = state_q;
    take_d       = take_q;
    eoi          = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_src = 1'b0;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    rf_write     = 1'b0;
    pc_src       = 1'b0;
    case (state_q)
      IDLE:   state_d = run ? FETCH : IDLE;
      FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        state_d  = mem_ready ? DECODE : FETCH;
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        take_d = take;
        if (mem_write_en || rd_select == 2'd1) state_d = MEM;
        else if (rf_write_en)                  state_d = WRITEBACK;
        else begin
          eoi    = 1'b1;
          pc_src = take;
        end
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_src = 1'b1;
        mem_we       = mem_write_en;
        if (mem_ready) begin
          eoi       = mem_write_en;
          pc_src    = mem_write_en & take_q;
          mdr_write = ~mem_write_en;
          state_d   = mem_write_en ? MEM : WRITEBACK;
        end
      end
      WRITEBACK: begin
        rf_write = 1'b1;
        eoi      = 1'b1;
        pc_src   = take_q;
      end
      default: state_d = state_q;
    endcase
    if (eoi) state_d = halt_req ? IDLE : FETCH;
    instret_d = instret_q + XLEN'(eoi);
`ifdef MULTICYCLE_TIMEOUT_EN
    // counter stays zero outside memory waits, so every FETCH/MEM entry starts fresh
    wait_d = '0;
    if ((state_q == FETCH || state_q == MEM) && !mem_ready) begin
      if (wait_q == WW'(TIMEOUT_CYCLES - 1)) state_d = FAULT;
      else                                   wait_d  = wait_q + 1'b1;
    end
`endif
  end
  assign pc_write = eoi;
  assign busy     = (state_q != IDLE);
  assign instret  = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random instruction stream checked cycle-by-cycle against a trace model.
module tb_multicycle_control;
  logic clk = 0, reset_n = 0, run = 0, halt_req = 0;
  logic jump = 0, branch = 0, branch_if_zero = 0, zero = 0;
  logic [1:0] rd_select = 0;
  logic rf_write_en = 0, mem_write_en = 0, mem_ready = 0;
  logic mem_req, mem_we, mem_addr_src, ir_write, mdr_write, rf_write, pc_write, pc_src, busy, fault;
  logic [31:0] instret;
  logic [9:0] outs;
  int n_vec = 0, n_err = 0;
  logic [31:0] cnt = 0;
  logic c_jump, c_branch, c_biz, c_zero, c_rfw, c_mw;
  logic [1:0] c_rds;

  typedef struct packed {logic rdy; logic run; logic halt; logic eoi; logic [9:0] exp;} step_t;
  step_t q[$];

  multicycle_control #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .halt_req(halt_req), .jump(jump), .branch(branch),
    .branch_if_zero(branch_if_zero), .zero(zero), .rd_select(rd_select), .rf_write_en(rf_write_en),
    .mem_write_en(mem_write_en), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_src(mem_addr_src), .ir_write(ir_write), .mdr_write(mdr_write), .rf_write(rf_write),
    .pc_write(pc_write), .pc_src(pc_src), .busy(busy), .fault(fault), .instret(instret));

  always #5 clk = ~clk;
  assign outs = {busy, mem_req, mem_we, mem_addr_src, ir_write, mdr_write, rf_write, pc_write, pc_src, fault};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [9:0] v(input bit mreq, we, as, irw, mdr, rfw, pcw, pcs);
    return {1'b1, mreq, we, as, irw, mdr, rfw, pcw, pcs, 1'b0};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rdy, input logic r, input logic h, input logic e, input logic [9:0] exp);
    q.push_back('{rdy: rdy, run: r, halt: h, eoi: e, exp: exp});
  endtask

  task automatic play();
    step_t s;
    while (q.size() != 0) begin
      s = q.pop_front();
      @(negedge clk);
      jump = c_jump; branch = c_branch; branch_if_zero = c_biz; zero = c_zero;
      rd_select = c_rds; rf_write_en = c_rfw; mem_write_en = c_mw;
      mem_ready = s.rdy; run = s.run; halt_req = s.halt;
      #1;
      check("outs", {22'd0, outs}, {22'd0, s.exp});
      check("instret", instret, cnt);
      if (s.eoi) cnt++;
    end
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 branch, 4 jal, 5 nop
  task automatic build(input int kind, input int fw, input int mw, input logic halt);
    logic ld, st, wb, take;
    ld = (kind == 1); st = (kind == 2); wb = (kind == 0 || kind == 1 || kind == 4);
    c_jump = (kind == 4); c_branch = (kind == 3); c_biz = rb(); c_zero = rb();
    c_rds = ld ? 2'd1 : (kind == 4) ? 2'd2 : 2'd0;
    c_rfw = wb; c_mw = st;
    take = c_jump || (c_branch && (c_biz == c_zero));
    for (int i = 0; i < fw; i++) push(0, rb(), rb(), 0, v(1, 0, 0, 0, 0, 0, 0, 0));
    push(1, rb(), rb(), 0, v(1, 0, 0, 1, 0, 0, 0, 0));
    push(rb(), rb(), rb(), 0, v(0, 0, 0, 0, 0, 0, 0, 0));
    if (ld || st || wb) push(rb(), rb(), rb(), 0, v(0, 0, 0, 0, 0, 0, 0, 0));
    else push(rb(), rb(), halt, 1, v(0, 0, 0, 0, 0, 0, 1, take));
    if (ld || st) begin
      for (int i = 0; i < mw; i++) push(0, rb(), rb(), 0, v(1, st, 1, 0, 0, 0, 0, 0));
      if (st) push(1, rb(), halt, 1, v(1, 1, 1, 0, 0, 0, 1, 0));
      else    push(1, rb(), rb(), 0, v(1, 0, 1, 0, 1, 0, 0, 0));
    end
    if (wb) push(rb(), rb(), halt, 1, v(0, 0, 0, 0, 0, 1, 1, take));
    if (halt) begin
      push(rb(), 0, rb(), 0, 10'd0);
      push(rb(), 1, rb(), 0, 10'd0);
    end
  endtask

  initial begin
    c_jump = 0; c_branch = 0; c_biz = 0; c_zero = 0; c_rds = 0; c_rfw = 0; c_mw = 0;
    repeat (2) @(negedge clk);
    check("rst_outs", {22'd0, outs}, 32'd0);
    check("rst_instret", instret, 32'd0);
    reset_n = 1;
    push(0, 1, 0, 0, 10'd0);
    play();
    for (int n = 0; n < 60; n++) begin
      build(n < 6 ? n : int'($urandom_range(0, 5)), $urandom_range(0, 2), $urandom_range(0, 2),
            (n == 59) || ($urandom_range(0, 5) == 0));
      play();
    end
    // start a load and assert reset while it waits in MEM
    build(1, 0, 2, 0);
    repeat (2) void'(q.pop_back());
    play();
    @(negedge clk);
    mem_ready = 0;
    #1;
    check("mem_req_before_rst", {31'd0, mem_req}, 32'd1);
    reset_n = 0;
    #1;
    check("mem_req_in_rst", {31'd0, mem_req}, 32'd0);
    check("instret_in_rst", instret, 32'd0);
    check("busy_in_rst", {31'd0, busy}, 32'd0);
`ifdef MULTICYCLE_TIMEOUT_EN
    cnt = 0;
    @(negedge clk);
    reset_n = 1;
    push(0, 1, 0, 0, 10'd0);
    for (int i = 0; i < 4; i++) push(0, 1, 0, 0, v(1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) push(rb(), 1, rb(), 0, 10'b10_0000_0001);
    play();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
